// File: rtl/karatsuba_10b_norm.sv
// Normalizer for a 10x10 multiplier product: edge capture -> normalize/round -> 2-entry output FIFO.
// Optional macro KARATSUBA_NORM_RNE_EN enables round-to-nearest-even; otherwise the fraction is truncated.
module karatsuba_10b_norm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prod_done,
  input  logic [19:0] prod,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  mant,
  output logic [4:0]  norm_exp,
  output logic        zero,
  output logic        inexact,
  output logic        err_drop
);

  typedef struct packed {
    logic [9:0] mant;
    logic [4:0] norm_exp;
    logic       zero;
    logic       inexact;
  } norm_t;

  logic        done_q;
  logic        primed;
  logic        done_edge;
  logic        capture;
  logic        cap_valid;
  logic [19:0] cap_prod;
  logic        cap_move;
  logic        norm_valid;
  logic        norm_adv;
  norm_t       norm_d;
  norm_t       norm_q;
  norm_t       head_q;
  norm_t       tail_q;
  logic [1:0]  fifo_cnt;
  logic        push;
  logic        pop;
  logic [2:0]  held;

  logic [4:0]  lead;
  logic [18:0] aligned;
  logic [9:0]  frac;
  logic        guard;
  logic        sticky;

  // primed masks the first cycle after reset so a level already high at release is not an edge.
  assign done_edge = primed & prod_done & ~done_q;
  assign held      = {2'b00, cap_valid} + {2'b00, norm_valid} + {1'b0, fifo_cnt};
  assign in_ready  = (held < 3'd3);
  assign capture   = done_edge & in_ready;

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = norm_valid & ((fifo_cnt != 2'd2) | pop);
  assign norm_adv  = ~norm_valid | push;
  assign cap_move  = cap_valid & norm_adv;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      primed     <= 1'b0;
      cap_valid  <= 1'b0;
      norm_valid <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      done_q <= prod_done;
      primed <= 1'b1;
      if (capture)       cap_valid <= 1'b1;
      else if (cap_move) cap_valid <= 1'b0;
      if (cap_move)      norm_valid <= 1'b1;
      else if (push)     norm_valid <= 1'b0;
      if (done_edge && !in_ready) err_drop <= 1'b1;
    end
  end

  // NOTE: pipeline data registers carry no reset; their valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (capture)  cap_prod <= prod;
    if (cap_move) norm_q   <= norm_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (cap_prod[i]) lead = 5'(i);
    end
    // Left-align so the leading one falls just above bit 18; the top bit is dropped by the cast.
    aligned = 19'(cap_prod << (5'd19 - lead));
    frac    = aligned[18:9];
    guard   = aligned[8];
    sticky  = |aligned[7:0];

    norm_d          = '0;
    norm_d.zero     = (cap_prod == 20'd0);
    norm_d.inexact  = guard | sticky;
`ifdef KARATSUBA_NORM_RNE_EN
    begin
      logic [10:0] rounded;
      rounded         = {1'b0, frac} + {10'd0, guard & (sticky | frac[0])};
      norm_d.mant     = rounded[9:0];
      norm_d.norm_exp = lead + {4'd0, rounded[10]};
    end
`else
    norm_d.mant     = frac;
    norm_d.norm_exp = lead;
`endif
  end

  // Two-register shift FIFO: outputs are taken straight from head_q, which is reset so they read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      fifo_cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) head_q <= norm_q;
          else                  tail_q <= norm_q;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head_q   <= tail_q;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_q <= norm_q;
          end else begin
            head_q <= tail_q;
            tail_q <= norm_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mant     = head_q.mant;
  assign norm_exp = head_q.norm_exp;
  assign zero     = head_q.zero;
  assign inexact  = head_q.inexact;

endmodule

// File: tb/tb_karatsuba_10b_norm.sv
// Scoreboard bench for karatsuba_10b_norm: arithmetic reference model, random and directed stimulus.
module tb_karatsuba_10b_norm;

  typedef struct packed {
    logic [9:0] mant;
    logic [4:0] norm_exp;
    logic       zero;
    logic       inexact;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prod_done;
  logic [19:0] prod;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  mant;
  logic [4:0]  norm_exp;
  logic        zero;
  logic        inexact;
  logic        err_drop;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  bit   rand_ready = 1'b0;

  karatsuba_10b_norm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_done (prod_done),
    .prod      (prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant      (mant),
    .norm_exp  (norm_exp),
    .zero      (zero),
    .inexact   (inexact),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: find the leading one, take the next ten bits, derive guard/sticky from the remainder.
  function automatic res_t model(input logic [19:0] v);
    res_t   r;
    longint x, m, rem, half;
    int     p;
    bit     g, s;
    r = '0;
    x = longint'(v);
    if (x == 0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 20; i++) if (x >= (longint'(1) << i)) p = i;
    g = 1'b0;
    s = 1'b0;
    if (p >= 10) begin
      m   = x >> (p - 10);
      rem = x - (m << (p - 10));
      if (p >= 11) begin
        half = longint'(1) << (p - 11);
        g    = (rem >= half);
        s    = ((rem % half) != 0);
      end
    end else begin
      m = x << (10 - p);
    end
    m = m % 1024;
    r.norm_exp = 5'(p);
    r.inexact  = g | s;
`ifdef KARATSUBA_NORM_RNE_EN
    if (g && (s || (m % 2) == 1)) m = m + 1;
    if (m == 1024) begin
      m          = 0;
      r.norm_exp = 5'(p + 1);
    end
`endif
    r.mant = 10'(m);
    return r;
  endfunction

  // Monitor: every accepted output is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got mant=%0h exp=%0d, required no output", mant, norm_exp);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("result", {16'd0, mant, norm_exp, zero, inexact}, {16'd0, e});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] v, input int hold);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=%b, required 1 within 500 cycles", in_ready);
    end else begin
      prod      = v;
      prod_done = 1'b1;
      sb.push_back(model(v));
      repeat (hold) tick();
      prod_done = 1'b0;
      tick();
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (6) tick();
  endtask

  function automatic logic [19:0] rand_prod();
    logic [19:0] v;
    case ($urandom_range(0, 4))
      0:       v = 20'($urandom);
      1:       v = 20'($urandom_range(0, 1023));
      2:       v = 20'($urandom_range(1, 15)) << $urandom_range(0, 16);
      3:       v = 20'hFFFFF;
      default: v = 20'd1 << $urandom_range(0, 19);
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] vals [4];
    rst_n     = 1'b0;
    prod_done = 1'b1;
    prod      = 20'h00400;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_mant",      32'(mant),      32'd0);
    check("rst_norm_exp",  32'(norm_exp),  32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_inexact",   32'(inexact),   32'd0);
    check("rst_err_drop",  32'(err_drop),  32'd0);

    // prod_done already high at release must not count as an edge.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) tick();
    check("no_edge_at_release", 32'(out_valid), 32'd0);
    prod_done = 1'b0;
    tick();

    // Latency: out_valid rises two cycles after the capturing edge.
    prod      = 20'h00001;
    prod_done = 1'b1;
    sb.push_back(model(20'h00001));
    @(posedge clk);
    @(negedge clk);
    check("lat_cap", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 prod_done = 1'b0;
    @(negedge clk);
    check("lat_norm", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_out", 32'(out_valid), 32'd1);
    tick();
    wait_drain(50);

    send(20'hFFFFF, 1);
    send(20'h00C01, 2);
    send(20'h00000, 1);
    send(20'h00400, 5);
    send(20'h003FF, 1);
    wait_drain(100);

    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) send(rand_prod(), int'($urandom_range(1, 3)));
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_drain(200);

    // Back-pressure: fourth edge is dropped and flagged.
    out_ready = 1'b0;
    vals[0] = 20'h12345;
    vals[1] = 20'h00C01;
    vals[2] = 20'h00003;
    vals[3] = 20'h80000;
    for (int j = 0; j < 4; j++) begin
      prod      = vals[j];
      prod_done = 1'b1;
      if (j < 3) sb.push_back(model(vals[j]));
      tick();
      prod_done = 1'b0;
      if (j == 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      tick();
    end
    check("bp_err_drop", 32'(err_drop), 32'd1);
    out_ready = 1'b1;
    wait_drain(50);
    check("err_drop_sticky", 32'(err_drop), 32'd1);

    // Reset in flight discards everything.
    out_ready = 1'b0;
    send(20'h00055, 1);
    send(20'h30000, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_err_drop",  32'(err_drop),  32'd0);
    check("midrst_mant",      32'(mant),      32'd0);
    check("midrst_norm_exp",  32'(norm_exp),  32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    check("no_stale", 32'(out_valid), 32'd0);
    send(20'h0ABCD, 1);
    wait_drain(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
